// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low patterns ({g,f,e,d,c,b,a}) and the blank BCD code.
package seg7_pkg;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] BLANK_BCD = 4'hF;
endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the BCD-to-7-segment encoder; flags patterns the encoder never emits.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_bcd,
    output logic       o_invalid
);

    always_comb begin
        o_bcd     = BLANK_BCD;
        o_invalid = 1'b0;
        case (i_seg)
            SEG_0:     o_bcd = 4'd0;
            SEG_1:     o_bcd = 4'd1;
            SEG_2:     o_bcd = 4'd2;
            SEG_3:     o_bcd = 4'd3;
            SEG_4:     o_bcd = 4'd4;
            SEG_5:     o_bcd = 4'd5;
            SEG_6:     o_bcd = 4'd6;
            SEG_7:     o_bcd = 4'd7;
            SEG_8:     o_bcd = 4'd8;
            SEG_9:     o_bcd = 4'd9;
            SEG_BLANK: o_bcd = BLANK_BCD;
            default:   o_invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_monitor.sv
// Watches multiplexed active-low segment/anode lines and reconstructs the BCD digit at each position.
module seg7_scan_monitor
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    upd,
    output logic                    frame_done,
    output logic                    err
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SW = NUM_DIGITS + 7;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_TGT = CW'(STABLE_CYCLES);

    logic [SW-1:0]           r_prev;
    logic [CW-1:0]           r_cnt;
    logic                    r_captured;
    logic [NUM_DIGITS-1:0]   r_mask;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_valid;
    logic                    r_upd;
    logic                    r_frame_done;
    logic                    r_err;

    logic [SW-1:0]         w_samp;
    logic                  w_same;
    logic [CW-1:0]         w_cnt_next;
    logic                  w_fire;
    logic [NUM_DIGITS-1:0] w_an_low;
    logic                  w_onehot;
    logic                  w_multi;
    logic [IW-1:0]         w_idx;
    logic [NUM_DIGITS-1:0] w_mask_next;
    logic [3:0]            w_bcd;
    logic                  w_invalid;

    seg7_decode u_decode (
        .i_seg     (seg),
        .o_bcd     (w_bcd),
        .o_invalid (w_invalid)
    );

    assign w_samp     = {an, seg};
    assign w_same     = (w_samp == r_prev);
    // A reset count of zero also lands on 1 here, so the first post-reset edge is always e1.
    assign w_cnt_next = !w_same ? CW'(1) :
                        (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
    assign w_fire     = (w_cnt_next == CNT_TGT) && !r_captured;

    assign w_an_low = ~an;
    assign w_onehot = (w_an_low != '0) &&
                      ((w_an_low & (w_an_low - NUM_DIGITS'(1))) == '0);
    assign w_multi  = (w_an_low != '0) && !w_onehot;
    assign w_mask_next = r_mask | w_an_low;

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_an_low[i]) w_idx = IW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev       <= '0;
            r_cnt        <= '0;
            r_captured   <= 1'b0;
            r_mask       <= '0;
            r_digits     <= {NUM_DIGITS{BLANK_BCD}};
            r_valid      <= '0;
            r_upd        <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_prev       <= w_samp;
            r_cnt        <= w_cnt_next;
            r_captured   <= w_same ? (r_captured | w_fire) : 1'b0;
            r_upd        <= 1'b0;
            r_frame_done <= 1'b0;

            if (w_fire && w_onehot) begin
                for (int d = 0; d < NUM_DIGITS; d++) begin
                    if (IW'(d) == w_idx) r_digits[4*d +: 4] <= w_bcd;
                end
                r_valid[w_idx] <= 1'b1;
                r_upd          <= 1'b1;
                if (w_invalid) r_err <= 1'b1;
                if (&w_mask_next) begin
                    r_frame_done <= 1'b1;
                    r_mask       <= '0;
                end else begin
                    r_mask <= w_mask_next;
                end
            end

            if (w_fire && w_multi) r_err <= 1'b1;
        end
    end

    assign digits      = r_digits;
    assign digit_valid = r_valid;
    assign upd         = r_upd;
    assign frame_done  = r_frame_done;
    assign err         = r_err;

endmodule

// File: tb/tb_seg7_scan_monitor.sv
// Randomized and directed bench for seg7_scan_monitor against a run-length reference model.
module tb_seg7_scan_monitor;
    localparam int ND = 4;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic [4*ND-1:0] digits;
    logic [ND-1:0] digit_valid;
    logic          upd, frame_done, err;

    int n_checks = 0;
    int n_errors = 0;

    // reference state
    logic [6:0]  pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int          m_digit [ND];
    logic [ND-1:0] m_valid, m_mask;
    logic        m_err, m_upd, m_fd;
    int          m_run;
    logic [6:0]  m_pseg;
    logic [ND-1:0] m_pan;
    int          upd_cnt, fd_cnt;

    seg7_scan_monitor #(.NUM_DIGITS(ND), .STABLE_CYCLES(N)) dut (
        .clk(clk), .rst(rst), .seg(seg), .an(an),
        .digits(digits), .digit_valid(digit_valid),
        .upd(upd), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int decode(input logic [6:0] s);
        if (s == 7'h7F) return 15;
        for (int k = 0; k < 10; k++) if (pat[k] == s) return k;
        return -1;
    endfunction

    function automatic logic [4*ND-1:0] exp_digits();
        logic [4*ND-1:0] v;
        for (int k = 0; k < ND; k++) v[4*k +: 4] = 4'(m_digit[k]);
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < ND; k++) m_digit[k] = 15;
        m_valid = '0; m_mask = '0; m_err = 1'b0;
        m_upd = 1'b0; m_fd = 1'b0; m_run = 0;
    endtask

    task automatic model_edge(input logic r, input logic [ND-1:0] a, input logic [6:0] s);
        int lows, idx, d;
        if (r) begin
            model_reset();
            return;
        end
        m_upd = 1'b0; m_fd = 1'b0;
        if (m_run > 0 && a == m_pan && s == m_pseg) m_run++;
        else m_run = 1;
        m_pan = a; m_pseg = s;
        if (m_run != N) return;
        lows = 0; idx = 0;
        for (int k = 0; k < ND; k++) if (!a[k]) begin lows++; idx = k; end
        if (lows > 1) m_err = 1'b1;
        if (lows == 1) begin
            d = decode(s);
            if (d < 0) begin m_err = 1'b1; d = 15; end
            m_digit[idx] = d;
            m_valid[idx] = 1'b1;
            m_upd = 1'b1;
            m_mask[idx] = 1'b1;
            if (&m_mask) begin m_fd = 1'b1; m_mask = '0; end
        end
    endtask

    task automatic step(input logic r, input logic [ND-1:0] a, input logic [6:0] s);
        rst = r; an = a; seg = s;
        @(posedge clk);
        model_edge(r, a, s);
        #1;
        chk("digits", 32'(digits), 32'(exp_digits()));
        chk("digit_valid", 32'(digit_valid), 32'(m_valid));
        chk("upd", 32'(upd), 32'(m_upd));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("err", 32'(err), 32'(m_err));
        if (upd) upd_cnt++;
        if (frame_done) fd_cnt++;
    endtask

    task automatic hold(input logic [ND-1:0] a, input logic [6:0] s, input int cyc);
        for (int k = 0; k < cyc; k++) step(1'b0, a, s);
    endtask

    initial begin
        logic [6:0] scan_seg [4];
        logic [6:0] rs;
        logic [ND-1:0] ra;
        int sel;
        scan_seg = '{7'h79, 7'h00, 7'h40, 7'h12};
        model_reset();
        m_pan = '1; m_pseg = '0;
        upd_cnt = 0; fd_cnt = 0;
        rst = 1'b1; an = '1; seg = 7'h7F;
        #1;
        step(1'b1, 4'hF, 7'h7F);
        step(1'b1, 4'hF, 7'h7F);
        chk("reset_digits", 32'(digits), 32'hFFFF);
        chk("reset_valid", 32'(digit_valid), 32'h0);

        // single digit held longer than the filter window
        upd_cnt = 0;
        hold(4'b1110, 7'h24, 3);
        chk("no_upd_before_eN", 32'(upd_cnt), 0);
        step(1'b0, 4'b1110, 7'h24);
        chk("upd_at_eN", 32'(upd), 1);
        hold(4'b1110, 7'h24, 5);
        chk("single_upd", 32'(upd_cnt), 1);
        chk("digit0_is_2", 32'(digits[3:0]), 2);
        chk("valid_0001", 32'(digit_valid), 32'b0001);

        // two full scans 1,8,0,5
        fd_cnt = 0;
        for (int f = 0; f < 2; f++)
            for (int d = 0; d < 4; d++)
                hold(~(4'b0001 << d), scan_seg[d], N);
        chk("scan_digits", 32'(digits), 32'h5081);
        chk("two_frames", 32'(fd_cnt), 2);

        // never stable long enough
        upd_cnt = 0;
        for (int k = 0; k < 8; k++) hold(4'b1101, (k % 2) ? 7'h30 : 7'h19, 3);
        chk("toggle_no_upd", 32'(upd_cnt), 0);
        chk("toggle_digits", 32'(digits), 32'h5081);

        // display off, then two anodes low
        hold(4'b1111, 7'h00, N + 2);
        chk("off_no_err", 32'(err), 0);
        chk("off_no_upd", 32'(upd_cnt), 0);
        hold(4'b1100, 7'h00, N);
        chk("multi_err", 32'(err), 1);
        chk("multi_no_write", 32'(digits), 32'h5081);

        // blank then invalid on digit 2
        step(1'b1, 4'hF, 7'h7F);
        hold(4'b1011, 7'h7F, N);
        chk("blank_F", 32'(digits[11:8]), 15);
        chk("blank_no_err", 32'(err), 0);
        hold(4'b1011, 7'h55, N);
        chk("invalid_F", 32'(digits[11:8]), 15);
        chk("invalid_err", 32'(err), 1);
        hold(4'b1110, 7'h79, N + 1);
        chk("err_sticky", 32'(err), 1);

        // reset interrupts a stable period
        hold(4'b0111, 7'h02, 3);
        step(1'b1, 4'b0111, 7'h02);
        chk("mid_reset_err", 32'(err), 0);
        chk("mid_reset_valid", 32'(digit_valid), 0);
        upd_cnt = 0;
        hold(4'b0111, 7'h02, 3);
        chk("post_reset_wait", 32'(upd_cnt), 0);
        step(1'b0, 4'b0111, 7'h02);
        chk("post_reset_capture", 32'(digits[15:12]), 6);

        // randomized scanning
        for (int t = 0; t < 300; t++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       rs = pat[$urandom_range(0, 9)];
            else if (sel == 7) rs = 7'h7F;
            else               rs = 7'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 7)       ra = ~(4'b0001 << $urandom_range(0, 3));
            else if (sel == 7) ra = 4'hF;
            else               ra = 4'($urandom);
            if ($urandom_range(0, 39) == 0) step(1'b1, ra, rs);
            hold(ra, rs, $urandom_range(1, 7));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
